ram_boot_loader: RTL and testbench
==================================

// Module: ram_boot_loader
// PURPOSE
//  Upstream feeder for the 256x16 program RAM of the accumulator CPU. While the CPU
//  is held in reset, accepts a stream of program words over a valid/ready port and
//  writes them to RAM at consecutive addresses from 0. Optionally zero-fills the rest
//  of RAM, then releases the CPU. Outputs drive the RAM we/d/addr through the top-level mux.
// PARAMETERS
//  ADDR_W     8    RAM address width
//  DATA_W     16   RAM word width
//  DEPTH      256  number of RAM words; must equal 2**ADDR_W
//  CLEAR_MEM  1    1 = zero-fill addresses after the last loaded word; 0 = leave them
// PORTS
//  clk        in   1        clock, all state on rising edge
//  Reset      in   1        synchronous, active-high reset
//  start      in   1        pulse; begins a load session (sampled only in IDLE)
//  ld_valid   in   1        ld_data/ld_last are valid
//  ld_data    in   DATA_W   program word
//  ld_last    in   1        qualifies the final word of the image
//  ld_ready   out  1        loader accepts a word this cycle
//  mem_we     out  1        RAM write enable (registered)
//  mem_addr   out  ADDR_W   RAM address (registered)
//  mem_d      out  DATA_W   RAM write data (registered)
//  cpu_rst    out  1        held high to keep CPU controller/registers in reset
//  done       out  1        image loaded (and cleared); CPU released
//  overflow   out  1        RAM filled without ld_last seen
//  word_cnt   out  ADDR_W+1 words accepted this session (0..DEPTH)
// BEHAVIOUR
//  Reset (any state): state=IDLE; cpu_rst=1; ld_ready=0; mem_we=0; mem_addr=0; mem_d=0;
//   done=0; overflow=0; word_cnt=0; ptr=0. RAM contents not touched; a partial image stays.
//  States: IDLE -> LOAD -> (CLEAR) -> RUN.
//  IDLE: ld_ready=0, mem_we=0. start=1 -> LOAD, ptr=0, word_cnt=0. ld_valid ignored.
//  LOAD: ld_ready=1 (combinational from state). Transfer = ld_valid & ld_ready.
//   On transfer: next cycle mem_we=1, mem_addr=ptr, mem_d=ld_data (latency 1);
//   ptr++, word_cnt++. No transfer -> mem_we=0 next cycle, addr/d hold.
//   Exit on transfer with ld_last=1 or ptr==DEPTH-1:
//    ptr==DEPTH-1 & !ld_last -> overflow=1 (sticky), go RUN (nothing left to clear).
//    ptr==DEPTH-1 &  ld_last -> RUN.
//    ptr<DEPTH-1, CLEAR_MEM=1 -> CLEAR; CLEAR_MEM=0 -> RUN.
//   ld_ready drops in the cycle after the exit transfer; extra words are not accepted.
//  CLEAR: ld_ready=0; each cycle mem_we=1, mem_addr=ptr, mem_d=0, ptr++; after writing
//   DEPTH-1 -> RUN. word_cnt not incremented.
//  RUN: mem_we=0 from first RUN cycle; cpu_rst=0 and done=1 registered on entry,
//   held until Reset. start, ld_valid ignored. ptr never wraps past DEPTH-1.
//  start while not IDLE: ignored. start & ld_valid in same IDLE cycle: word not taken.
//  Reset asserted mid-LOAD/CLEAR: abandons session next edge; no further writes.
//  word_cnt width ADDR_W+1 so a full image reads DEPTH (256), not 0.
// STRUCTURE
//  Shared package/header: state encodings (IDLE=2'd0, LOAD=2'd1, CLEAR=2'd2, RUN=2'd3),
//   ADDR_W/DATA_W/DEPTH defaults shared with RAM, ALU, datapath.
//  One sub-module: addr_counter (ADDR_W-bit loadable up-counter with clear, inc, and
//   terminal-count flag tc = ptr==DEPTH-1); FSM and output registers in the top.
// TESTING
//  1 Reset, start, 3 words 16'h1234,16'h5678,16'hABCD (last on 3rd), CLEAR_MEM=0 ->
//    we at addr 0,1,2 with those data; word_cnt=3; done=1, cpu_rst=0 next cycle.
//  2 Same with CLEAR_MEM=1 -> addrs 3..255 written 0, one per cycle; done after
//    addr 255 write (253 clear cycles); overflow=0.
//  3 256 words, no ld_last -> last write addr 255; overflow=1; word_cnt=256; 257th
//    ld_valid sees ld_ready=0.
//  4 ld_valid toggled 1,0,0,1 -> writes only on accepted cycles; addresses contiguous.
//  5 Reset after 5 words in LOAD -> next edge IDLE, cpu_rst=1, we=0, word_cnt=0;
//    start pulses in LOAD/RUN have no effect.
//  6 start with ld_valid high same cycle -> that word not written; first write in LOAD.

Source files
------------

// File: rtl/ram_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// ram_boot_loader_pkg
//   Shared definitions for the accumulator CPU program-RAM boot loader.
//   Holds the RAM geometry defaults that the RAM, ALU and datapath also use,
//   the loader state encoding, and a small helper that picks the state that
//   follows the final accepted word of an image.
// ---------------------------------------------------------------------------
package ram_boot_loader_pkg;

  // RAM geometry shared with the program RAM, ALU and datapath.
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;

  // Loader states. The encoding is fixed because other blocks decode it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // State after the final word of a load session has been accepted.
  // When the pointer already sits on the last RAM word there is nothing left
  // to clear, so the loader releases the CPU straight away.
  function automatic state_e load_exit_state(input logic tc, input logic clear_mem);
    if (tc || !clear_mem) begin
      return ST_RUN;
    end
    return ST_CLEAR;
  endfunction

endpackage

// File: rtl/ram_boot_loader_if.sv
// ---------------------------------------------------------------------------
// ram_boot_loader_if
//   Bundles the program-word stream (valid/ready/data/last) and the RAM
//   write port that the boot loader drives.
//   Signals:
//     ld_valid  word on ld_data/ld_last is valid          (feeder -> loader)
//     ld_data   program word                              (feeder -> loader)
//     ld_last   marks the final word of the image         (feeder -> loader)
//     ld_ready  loader accepts a word this cycle          (loader -> feeder)
//     mem_we    RAM write enable                          (loader -> RAM mux)
//     mem_addr  RAM write address                         (loader -> RAM mux)
//     mem_d     RAM write data                            (loader -> RAM mux)
//   Modports:
//     master  the feeder side (drives the stream, observes the RAM port)
//     slave   the loader itself
// ---------------------------------------------------------------------------
interface ram_boot_loader_if
  import ram_boot_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_d;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_d
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready,
    output mem_we,
    output mem_addr,
    output mem_d
  );

endinterface

// File: rtl/ram_boot_loader_addr_counter.sv
// ---------------------------------------------------------------------------
// addr_counter
//   RAM address pointer for the boot loader. Loadable up-counter with a
//   synchronous clear and a terminal-count flag raised on the last RAM word.
//   The counter saturates on the last word, so the loader never wraps back
//   onto address 0 and overwrites the start of the image.
//   Ports:
//     clk         clock, rising edge
//     Reset       synchronous active-high reset (pointer -> 0)
//     clr_i       clear pointer to 0 (highest priority after Reset)
//     load_i      load pointer with load_val_i
//     load_val_i  value loaded when load_i is high
//     inc_i       advance pointer by one (held at DEPTH-1 once reached)
//     ptr_o       current pointer
//     tc_o        pointer equals DEPTH-1
// ---------------------------------------------------------------------------
module addr_counter
  import ram_boot_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              tc_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic              tc;

  assign tc = (ptr_q == LAST_ADDR);

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i && !tc) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;
  assign tc_o  = tc;

endmodule

// File: rtl/ram_boot_loader.sv
// ---------------------------------------------------------------------------
// ram_boot_loader
//   Upstream feeder for the program RAM of the accumulator CPU. While the CPU
//   is held in reset it accepts a stream of program words and writes them to
//   RAM at consecutive addresses from 0, optionally zero-fills the remainder
//   of RAM, then releases the CPU. The RAM write port is registered and is
//   routed through the top-level RAM mux.
//   Parameters:
//     ADDR_W     RAM address width
//     DATA_W     RAM word width
//     DEPTH      number of RAM words, must equal 2**ADDR_W
//     CLEAR_MEM  1 = zero-fill addresses after the last loaded word
//   Ports:
//     clk         clock, all state on rising edge
//     Reset       synchronous active-high reset (RAM contents untouched)
//     start_i     pulse, begins a load session (only honoured in IDLE)
//     ld          stream + RAM write port bundle (slave side)
//     cpu_rst_o   keeps the CPU controller/registers in reset
//     done_o      image loaded (and cleared), CPU released
//     overflow_o  RAM filled before ld_last was seen (sticky)
//     word_cnt_o  words accepted this session, 0..DEPTH
// ---------------------------------------------------------------------------
module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CLEAR_MEM = 1
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                start_i,
  ram_boot_loader_if.slave    ld,
  output logic                cpu_rst_o,
  output logic                done_o,
  output logic                overflow_o,
  output logic [ADDR_W:0]     word_cnt_o
);

  localparam logic CLEAR_EN = (CLEAR_MEM != 0);

  state_e            state_q;
  state_e            state_d;

  logic              mem_we_q;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_d_q;
  logic [DATA_W-1:0] mem_d_d;

  logic              cpu_rst_q;
  logic              cpu_rst_d;
  logic              done_q;
  logic              done_d;
  logic              overflow_q;
  logic              overflow_d;
  // One bit wider than the address so a full image reads DEPTH, not 0.
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W:0]   word_cnt_d;

  logic              ptr_clr;
  logic              ptr_inc;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_tc;
  logic              xfer;

  addr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_counter (
    .clk        (clk),
    .Reset      (Reset),
    .clr_i      (ptr_clr),
    .load_i     (1'b0),
    .load_val_i ({ADDR_W{1'b0}}),
    .inc_i      (ptr_inc),
    .ptr_o      (ptr),
    .tc_o       (ptr_tc)
  );

  // Ready is decoded straight from the state so it drops in the cycle after
  // the exit transfer and no extra word slips in.
  assign ld.ld_ready = (state_q == ST_LOAD);
  assign xfer        = ld.ld_valid && (state_q == ST_LOAD);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    word_cnt_d = word_cnt_q;
    ptr_clr    = 1'b0;
    ptr_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A word presented alongside start is not taken: ready is low here.
        if (start_i) begin
          state_d    = ST_LOAD;
          ptr_clr    = 1'b1;
          word_cnt_d = '0;
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr;
          mem_d_d    = ld.ld_data;
          word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
          // The counter saturates on the last word, so incrementing on the
          // exit transfer is harmless and points CLEAR at the next address.
          ptr_inc    = 1'b1;
          if (ld.ld_last || ptr_tc) begin
            state_d = load_exit_state(ptr_tc, CLEAR_EN);
            if (ptr_tc && !ld.ld_last) begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      ST_CLEAR: begin
        mem_we_d   = 1'b1;
        mem_addr_d = ptr;
        mem_d_d    = '0;
        ptr_inc    = 1'b1;
        if (ptr_tc) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Terminal until Reset: start and stream input are ignored.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // done/cpu_rst are registered so they change on the edge entering RUN.
    if (state_d == ST_RUN) begin
      done_d    = 1'b1;
      cpu_rst_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign ld.mem_we   = mem_we_q;
  assign ld.mem_addr = mem_addr_q;
  assign ld.mem_d    = mem_d_q;

  assign cpu_rst_o   = cpu_rst_q;
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;
  assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_ram_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_boot_loader
//   Two loaders (CLEAR_MEM=0 and CLEAR_MEM=1) share one stimulus stream.
//   The driver decides from the session rules which words are accepted and
//   queues the RAM writes each loader must make; a monitor pops and compares
//   every write the loaders present.
// ---------------------------------------------------------------------------
module tb_ram_boot_loader;

  logic        clk;
  logic        Reset;
  logic        start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;

  logic       cpu_rst0, done0, ovf0;
  logic       cpu_rst1, done1, ovf1;
  logic [8:0] wc0, wc1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [23:0] q0[$];
  logic [23:0] q1[$];

  ram_boot_loader_if #(.ADDR_W(8), .DATA_W(16)) bus0 ();
  ram_boot_loader_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();

  assign bus0.ld_valid = ld_valid;
  assign bus0.ld_data  = ld_data;
  assign bus0.ld_last  = ld_last;
  assign bus1.ld_valid = ld_valid;
  assign bus1.ld_data  = ld_data;
  assign bus1.ld_last  = ld_last;

  ram_boot_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .CLEAR_MEM(0)) dut0 (
    .clk(clk), .Reset(Reset), .start_i(start), .ld(bus0),
    .cpu_rst_o(cpu_rst0), .done_o(done0), .overflow_o(ovf0), .word_cnt_o(wc0)
  );

  ram_boot_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .CLEAR_MEM(1)) dut1 (
    .clk(clk), .Reset(Reset), .start_i(start), .ld(bus1),
    .cpu_rst_o(cpu_rst1), .done_o(done1), .overflow_o(ovf1), .word_cnt_o(wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitor: every RAM write must match the head of its queue.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (bus0.mem_we === 1'b1) begin
        if (q0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL wr0_unexpected: got addr %0h data %0h expected no write", bus0.mem_addr, bus0.mem_d);
        end else begin
          e = q0.pop_front();
          chk("wr0", {bus0.mem_addr, bus0.mem_d}, e);
        end
      end
      if (bus1.mem_we === 1'b1) begin
        if (q1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL wr1_unexpected: got addr %0h data %0h expected no write", bus1.mem_addr, bus1.mem_d);
        end else begin
          e = q1.pop_front();
          chk("wr1", {bus1.mem_addr, bus1.mem_d}, e);
        end
      end
    end
  end

  task automatic chk_reset_state();
    chk("rst_ready0", bus0.ld_ready, 0); chk("rst_ready1", bus1.ld_ready, 0);
    chk("rst_we0", bus0.mem_we, 0);      chk("rst_we1", bus1.mem_we, 0);
    chk("rst_addr0", bus0.mem_addr, 0);  chk("rst_addr1", bus1.mem_addr, 0);
    chk("rst_d0", bus0.mem_d, 0);        chk("rst_d1", bus1.mem_d, 0);
    chk("rst_cpu0", cpu_rst0, 1);        chk("rst_cpu1", cpu_rst1, 1);
    chk("rst_done0", done0, 0);          chk("rst_done1", done1, 0);
    chk("rst_ovf0", ovf0, 0);            chk("rst_ovf1", ovf1, 0);
    chk("rst_wc0", wc0, 0);              chk("rst_wc1", wc1, 0);
  endtask

  task automatic apply_reset();
    Reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    @(posedge clk); #1;
    chk_reset_state();
    Reset = 1'b0;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    q0.delete(); q1.delete();
  endtask

  // One load session. vmode: 0 always valid, 1 valid pattern 1,0,0,1,
  // 2 random. rst_after>0 abandons the session by Reset after that many words.
  task automatic run_session(input int nwords, input bit with_last, input int vmode,
                             input bit sv_same, input bit noise, input int rst_after,
                             input bit fixed);
    int sent, cyc, m_ptr, clr_n, k;
    bit m_load, m_ovf, v, aborted;
    logic [15:0] w;
    logic [15:0] fixed_words [3];
    fixed_words[0] = 16'h1234; fixed_words[1] = 16'h5678; fixed_words[2] = 16'hABCD;
    sent = 0; cyc = 0; m_ptr = 0; m_ovf = 1'b0; aborted = 1'b0;

    // Start cycle; a word presented here belongs to IDLE and is dropped.
    start = 1'b1; ld_valid = sv_same; ld_data = 16'($urandom); ld_last = 1'b0;
    chk("ready_idle0", bus0.ld_ready, 0); chk("ready_idle1", bus1.ld_ready, 0);
    @(posedge clk); #1;
    m_load = 1'b1;

    while (m_load && !aborted) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      w = (fixed && sent < 3) ? fixed_words[sent] : 16'($urandom);
      ld_valid = v; ld_data = w;
      ld_last  = v && with_last && (sent == nwords - 1);
      start    = noise && ($urandom_range(0, 3) == 0);
      chk("ready_load0", bus0.ld_ready, 1); chk("ready_load1", bus1.ld_ready, 1);
      if (v) begin
        q0.push_back({8'(m_ptr), w});
        q1.push_back({8'(m_ptr), w});
        sent++;
        if (ld_last || m_ptr == 255) begin
          m_load = 1'b0;
          m_ovf  = !ld_last;
        end else begin
          m_ptr++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (m_load && rst_after > 0 && sent == rst_after) aborted = 1'b1;
      if (cyc > 3000) begin
        chk("load_timeout", cyc, 0);
        aborted = 1'b1;
      end
    end

    if (aborted) begin
      // Reset lands while a further word is offered: it must not be written.
      Reset = 1'b1; start = 1'b0; ld_valid = 1'b1; ld_data = 16'($urandom); ld_last = 1'b0;
      @(posedge clk); #1;
      Reset = 1'b0; ld_valid = 1'b0;
      chk_reset_state();
      chk("abort_q0", q0.size(), 0);
      chk("abort_q1", q1.size(), 0);
      q0.delete(); q1.delete();
      return;
    end

    // First cycle after the exit transfer.
    start = 1'b0; ld_last = 1'b0; ld_valid = 1'b1; ld_data = 16'($urandom);
    chk("ready_exit0", bus0.ld_ready, 0); chk("ready_exit1", bus1.ld_ready, 0);
    chk("done0", done0, 1);  chk("cpu_rst0", cpu_rst0, 0);
    chk("wc0", wc0, sent);   chk("wc1", wc1, sent);
    chk("ovf0", ovf0, m_ovf); chk("ovf1", ovf1, m_ovf);

    clr_n = 255 - m_ptr;
    for (int a = m_ptr + 1; a < 256; a++) q1.push_back({8'(a), 16'h0000});
    if (clr_n == 0) begin
      chk("done1_noclear", done1, 1);
    end else begin
      chk("done1_early", done1, 0);
      k = 0;
      while (done1 !== 1'b1 && k < 400) begin
        ld_valid = 1'($urandom_range(0, 1)); ld_data = 16'($urandom);
        @(posedge clk); #1;
        k++;
        chk("ready_clear1", bus1.ld_ready, 0);
      end
      chk("clear_cycles", k, clr_n);
      chk("cpu_rst1", cpu_rst1, 0);
      chk("ovf1_after_clear", ovf1, m_ovf);
    end

    // RUN: start pulses and offered words change nothing.
    repeat (3) begin
      start = 1'b1; ld_valid = 1'b1; ld_data = 16'($urandom);
      @(posedge clk); #1;
      chk("run_ready0", bus0.ld_ready, 0); chk("run_ready1", bus1.ld_ready, 0);
      chk("run_done0", done0, 1);          chk("run_done1", done1, 1);
      chk("run_cpu0", cpu_rst0, 0);        chk("run_cpu1", cpu_rst1, 0);
      chk("run_wc0", wc0, sent);           chk("run_wc1", wc1, sent);
    end
    start = 1'b0; ld_valid = 1'b0;
    @(posedge clk); #1;
    apply_reset();
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Three fixed words with last on the third (dut1 clears 3..255).
    run_session(3, 1'b1, 0, 1'b0, 1'b0, 0, 1'b1);
    // 256 words without last: overflow, 257th word refused.
    run_session(256, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    // 256 words with last on the final one: no overflow, nothing to clear.
    run_session(256, 1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
    // Valid pattern 1,0,0,1.
    run_session(6, 1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
    // Reset after five words, with start noise during LOAD.
    run_session(20, 1'b1, 0, 1'b0, 1'b1, 5, 1'b0);
    // start and ld_valid in the same IDLE cycle.
    run_session(4, 1'b1, 2, 1'b1, 1'b1, 0, 1'b0);
    // Randomised sessions.
    for (int s = 0; s < 6; s++) begin
      run_session(int'($urandom_range(1, 40)), 1'b1, 2, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
